// File: rtl/alu_pkg.sv
// alu_pkg: ALU status flag bundle that is shared with the status register.
package alu_pkg;
  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } alu_status_t;
endpackage

// File: rtl/status_pkg.sv
// status_pkg: status word layout, branch condition codes and the condition evaluator.
package status_pkg;
  import alu_pkg::*;
  typedef enum logic [3:0] {
    COND_AL, COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS,
    COND_VC, COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_NV
  } cond_e;
  typedef struct packed {
    logic        err;
    logic        mode;
    logic        imask;
    alu_status_t flags;
  } status_t;
  localparam int BIT_V     = 0;
  localparam int BIT_C     = 1;
  localparam int BIT_Z     = 2;
  localparam int BIT_N     = 3;
  localparam int BIT_IMASK = 4;
  localparam int BIT_MODE  = 5;
  localparam int BIT_ERR   = 6;
  localparam status_t STATUS_RST = '{err: 1'b0, mode: 1'b1, imask: 1'b1, flags: '0};
  function automatic logic cond_eval(input cond_e c, input alu_status_t f);
    logic ge;
    logic r;
    ge = f.negative == f.overflow;
    r  = 1'b0;
    case (c)
      COND_AL: r = 1'b1;
      COND_EQ: r = f.zero;
      COND_NE: r = !f.zero;
      COND_CS: r = f.carry;
      COND_CC: r = !f.carry;
      COND_MI: r = f.negative;
      COND_PL: r = !f.negative;
      COND_VS: r = f.overflow;
      COND_VC: r = !f.overflow;
      COND_HI: r = f.carry & !f.zero;
      COND_LS: r = !f.carry | f.zero;
      COND_GE: r = ge;
      COND_LT: r = !ge;
      COND_GT: r = !f.zero & ge;
      COND_LE: r = f.zero | !ge;
      default: r = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/status_reg_save_stack.sv
// save_stack: LIFO of 6-bit status snapshots; callers must not push when full or pop when empty.
module save_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [5:0] din,
  output logic [5:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [PW-1:0] sp_q, sp_d, sp_m1;
  logic [5:0]    mem_q [2**AW];
  logic [5:0]    mem_d [2**AW];
  always_comb begin
    sp_m1 = sp_q - PW'(1);
    sp_d  = push ? sp_q + PW'(1) : pop ? sp_m1 : sp_q;
    mem_d = mem_q;
    if (push) mem_d[sp_q[AW-1:0]] = din;
  end
  always_ff @(posedge clk) begin
    sp_q  <= rst ? '0 : sp_d;
    mem_q <= mem_d;
  end
  assign dout  = mem_q[sp_m1[AW-1:0]];
  assign full  = sp_q == PW'(DEPTH);
  assign empty = sp_q == '0;
endmodule

// File: rtl/status_reg.sv
// status_reg: CPU status register with ALU flag capture, branch condition and interrupt save stack.
// STATUS_SAVE_STACK_EN selects a STACK_DEPTH-deep save stack; otherwise a single shadow entry.
module status_reg
  import alu_pkg::*;
  import status_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             alu_ld,
  input  alu_status_t      alu_status,
  input  logic             push,
  input  logic             pop,
  input  cond_e            cond,
  output logic             cond_met,
  output logic             imask,
  output logic             supervisor,
  output logic             stack_empty,
  output logic             stack_full
);
`ifdef STATUS_SAVE_STACK_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  localparam int DEPTH = 1 + 0 * STACK_DEPTH;
`endif
  status_t    s_q, s_d;
  logic       push_en, pop_en;
  logic [5:0] top;
  logic       unused_data;
  assign unused_data = ^data_in[WIDTH-1:7];
  save_stack #(.DEPTH(DEPTH)) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push_en),
    .pop  (pop_en),
    .din  (s_q[5:0]),
    .dout (top),
    .full (stack_full),
    .empty(stack_empty)
  );
  always_comb begin
    s_d     = s_q;
    push_en = 1'b0;
    pop_en  = 1'b0;
    if (push && pop) s_d.err = 1'b1;
    else if (push) begin
      push_en   = !stack_full;
      s_d.err   = s_q.err | stack_full;
      s_d.imask = s_q.imask | !stack_full;
      s_d.mode  = s_q.mode | !stack_full;
    end else if (pop) begin
      pop_en   = !stack_empty;
      s_d.err  = s_q.err | stack_empty;
      s_d[5:0] = stack_empty ? s_q[5:0] : top;
    end else if (ld) begin
      s_d[5:0] = data_in[5:0];
      s_d.err  = s_q.err & data_in[BIT_ERR];
    end else if (alu_ld) s_d.flags = alu_status;
  end
  always_ff @(posedge clk) s_q <= rst ? STATUS_RST : s_d;
  assign data_out   = oe ? {{(WIDTH-7){1'b0}}, s_q} : {WIDTH{1'bz}};
  assign cond_met   = cond_eval(cond, s_q.flags);
  assign imask      = s_q.imask;
  assign supervisor = s_q.mode;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed and randomized checks of status_reg against a behavioural model.
module tb_status_reg;
  import alu_pkg::*;
  import status_pkg::*;
  localparam int W = 32;
`ifdef STATUS_SAVE_STACK_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 0, rst = 0, oe = 1, ld = 0, alu_ld = 0, push = 0, pop = 0;
  logic [W-1:0] data_in = '0;
  wire  [W-1:0] data_out;
  alu_status_t alu_status = '0;
  cond_e cond = COND_AL;
  logic cond_met, imask, supervisor, stack_empty, stack_full;
  int tests = 0, fails = 0;
  logic [6:0] m_word;
  logic [5:0] m_stack [$];

  status_reg #(.WIDTH(W), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .oe(oe), .ld(ld), .data_in(data_in), .data_out(data_out),
    .alu_ld(alu_ld), .alu_status(alu_status), .push(push), .pop(pop), .cond(cond),
    .cond_met(cond_met), .imask(imask), .supervisor(supervisor),
    .stack_empty(stack_empty), .stack_full(stack_full)
  );
  always #5 clk = ~clk;

  function automatic bit ref_cond(input int c, input logic [6:0] w);
    bit n, z, cy, v;
    n = w[3]; z = w[2]; cy = w[1]; v = w[0];
    case (c)
      0: return 1;            1: return z;             2: return !z;
      3: return cy;           4: return !cy;           5: return n;
      6: return !n;           7: return v;             8: return !v;
      9: return cy && !z;     10: return !cy || z;     11: return n == v;
      12: return n != v;      13: return !z && n == v; 14: return z || n != v;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit r, input bit pu, input bit po, input bit l,
                      input logic [W-1:0] d, input bit al, input logic [3:0] a);
    rst = r; push = pu; pop = po; ld = l; data_in = d; alu_ld = al;
    alu_status = alu_status_t'(a);
    if (r) begin m_word = 7'h30; m_stack.delete(); end
    else if (pu && po) m_word[6] = 1;
    else if (pu) begin
      if (m_stack.size() == DEPTH) m_word[6] = 1;
      else begin m_stack.push_back(m_word[5:0]); m_word[5:4] = 2'b11; end
    end else if (po) begin
      if (m_stack.size() == 0) m_word[6] = 1;
      else m_word[5:0] = m_stack.pop_back();
    end else if (l) begin
      m_word[5:0] = d[5:0];
      if (!d[6]) m_word[6] = 0;
    end else if (al) m_word[3:0] = a;
    @(posedge clk); #1;
    rst = 0; push = 0; pop = 0; ld = 0; alu_ld = 0;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (data_out !== 32'h30) begin fails++; $display("FAIL reset_word got %h exp %h", data_out, 32'h30); end
    tests++; if (stack_empty !== 1 || stack_full !== 0) begin fails++; $display("FAIL reset_stack got e=%b f=%b exp e=1 f=0", stack_empty, stack_full); end
    tests++; if (imask !== 1 || supervisor !== 1) begin fails++; $display("FAIL reset_mode got im=%b sv=%b exp 1 1", imask, supervisor); end
  endtask

  task automatic test_alu_cond;
    bit exp_c [5] = '{1, 1, 0, 1, 1};
    cond_e cs [5] = '{COND_EQ, COND_CS, COND_HI, COND_LS, COND_GE};
    step(0, 0, 0, 0, 0, 1, 4'b0110);
    tests++; if (data_out !== 32'h36) begin fails++; $display("FAIL alu_word got %h exp %h", data_out, 32'h36); end
    for (int i = 0; i < 5; i++) begin
      cond = cs[i]; #1;
      tests++; if (cond_met !== exp_c[i]) begin fails++; $display("FAIL alu_cond_%0d got %b exp %b", cs[i], cond_met, exp_c[i]); end
    end
  endtask

  task automatic test_ld_priority;
    bit exp_c [3] = '{0, 1, 0};
    cond_e cs [3] = '{COND_LT, COND_LE, COND_NV};
    step(0, 0, 0, 1, 32'h0F, 1, 4'h0);
    tests++; if (data_out !== 32'h0F) begin fails++; $display("FAIL ld_wins got %h exp %h", data_out, 32'h0F); end
    for (int i = 0; i < 3; i++) begin
      cond = cs[i]; #1;
      tests++; if (cond_met !== exp_c[i]) begin fails++; $display("FAIL ld_cond_%0d got %b exp %b", cs[i], cond_met, exp_c[i]); end
    end
  endtask

  task automatic test_push_pop;
    step(0, 0, 0, 1, 32'h03, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    tests++; if (data_out !== 32'h33) begin fails++; $display("FAIL push_word got %h exp %h", data_out, 32'h33); end
    step(0, 0, 0, 0, 0, 1, 4'h0);
    tests++; if (data_out !== 32'h30) begin fails++; $display("FAIL push_alu got %h exp %h", data_out, 32'h30); end
    step(0, 0, 1, 0, 0, 0, 0);
    tests++; if (data_out !== 32'h03 || stack_empty !== 1) begin fails++; $display("FAIL pop_word got %h e=%b exp 03 e=1", data_out, stack_empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 0, 0);
    tests++; if (stack_full !== 1 || data_out[6] !== 0) begin fails++; $display("FAIL full_after_depth got f=%b err=%b exp f=1 err=0", stack_full, data_out[6]); end
    step(0, 1, 0, 0, 0, 0, 0);
    tests++; if (data_out !== {25'b0, m_word} || m_word[6] !== 1 || stack_full !== 1) begin fails++; $display("FAIL over_push got %h f=%b exp %h f=1", data_out, stack_full, m_word); end
    step(0, 0, 0, 1, 0, 0, 0);
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL err_clear got %h exp 0", data_out); end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    tests++; if (data_out !== {25'b0, m_word} || stack_empty !== 1) begin fails++; $display("FAIL under_pop got %h e=%b exp %h e=1", data_out, stack_empty, m_word); end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 1, 32'h0A, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    tests++; if (data_out !== 32'h7A || stack_empty !== 0) begin fails++; $display("FAIL push_pop_same got %h e=%b exp 7a e=0", data_out, stack_empty); end
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (data_out !== 32'h30 || stack_empty !== 1) begin fails++; $display("FAIL rst_mid got %h e=%b exp 30 e=1", data_out, stack_empty); end
  endtask

  task automatic test_random;
    int op, c;
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      step(op == 9 && $urandom_range(0, 3) == 0, op == 0 || op == 1 || op == 8, op == 2 || op == 3 || op == 8,
           op == 4 || op == 6 || op == 7, $urandom, op == 5 || op == 6 || op == 7, 4'($urandom));
      c = $urandom_range(0, 15);
      cond = cond_e'(c); #1;
      tests++;
      if (data_out !== {25'b0, m_word} || cond_met !== ref_cond(c, m_word) || imask !== m_word[4] ||
          supervisor !== m_word[5] || stack_empty !== (m_stack.size() == 0) || stack_full !== (m_stack.size() == DEPTH)) begin
        fails++;
        $display("FAIL rand_%0d got w=%h c%0d=%b e=%b f=%b exp w=%h c=%b depth=%0d", k, data_out, c, cond_met,
                 stack_empty, stack_full, m_word, ref_cond(c, m_word), m_stack.size());
      end
    end
  endtask

  initial begin
    m_word = 7'h30;
    test_reset;
    test_alu_cond;
    test_ld_priority;
    test_push_pop;
    test_overflow;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
